// File: rtl/loader_pkg.sv
// Shared definitions for the program loader.
//   state_t       : loader FSM states
//   err_t         : error code type, with ERR_NONE / ERR_LEN / ERR_CSUM
//   LOADER_DEPTH  : default instruction-memory capacity in words
package loader_pkg;

    localparam int unsigned LOADER_DEPTH = 1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_FLUSH,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef logic [1:0] err_t;

    localparam err_t ERR_NONE = 2'b00;
    localparam err_t ERR_LEN  = 2'b01;
    localparam err_t ERR_CSUM = 2'b10;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
//   in_valid/in_data/in_ready : host byte stream (valid/ready handshake)
//   wr_en/wr_addr/wr_data     : instruction-memory write strobe, word address, word
// Modports: master = host/memory side, slave = loader side.
interface prog_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/prog_loader_word_packer.sv
// word_packer: packs bytes MSB-first into 32-bit words.
//   clk, rst    : clock, asynchronous active-low reset
//   clr         : restart packing at byte 0 (new load)
//   byte_valid  : byte_data is consumed this cycle
//   byte_data   : stream byte
//   word_valid  : one-cycle pulse, cycle after the fourth byte of a word
//   word_data   : packed word, stable while word_valid is high
//   byte_cnt    : position of the next byte within the current word
module word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data,
    output logic [1:0]  byte_cnt
);
    logic [23:0] shift_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q    <= '0;
            byte_cnt   <= '0;
            word_valid <= 1'b0;
            word_data  <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clr) begin
                byte_cnt <= '0;
            end else if (byte_valid) begin
                shift_q  <= {shift_q[15:0], byte_data};
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    word_data  <= {shift_q, byte_data};
                    word_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads a length-prefixed byte image into instruction memory and
// holds the core in reset until the whole image has been written.
//   clk, rst      : clock, asynchronous active-low reset
//   start         : one-cycle pulse beginning a load (honoured in IDLE/DONE/ERR)
//   bus           : byte stream in, instruction-memory write port out
//   cpu_rst       : active-high core reset, low only in DONE
//   done          : image loaded, core running
//   err           : ERR_NONE / ERR_LEN (length > DEPTH) / ERR_CSUM (checksum mismatch)
//   words_loaded  : words written during the current load
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte covering the length bytes and all data bytes.
module prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH  = LOADER_DEPTH,
    parameter int unsigned ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    prog_loader_if.slave bus,
    output logic        cpu_rst,
    output logic        done,
    output err_t        err,
    output logic [10:0] words_loaded
);
    state_t            state_q, state_d;
    logic              in_ready, take, start_go, err_set, last_word, pk_valid;
    err_t              err_code;
    logic [7:0]        len_hi_q;
    logic [15:0]       len_q, len_n;
    logic [ADDR_W:0]   word_idx;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        byte_cnt;
    logic              wr_en;
    logic [31:0]       wr_data;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    assign take     = bus.in_valid && in_ready;
    assign len_n    = {len_hi_q, bus.in_data};
    assign pk_valid = take && (state_q == ST_DATA);
    // word_idx counts words whose fourth byte has been taken; the current
    // word is the last one when word_idx + 1 equals the length.
    assign last_word = (17'(word_idx) + 17'd1) == {1'b0, len_q};

    assign bus.in_ready = in_ready;
    assign bus.wr_en    = wr_en;
    assign bus.wr_addr  = addr_q;
    assign bus.wr_data  = wr_data;

    word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_go),
        .byte_valid (pk_valid),
        .byte_data  (bus.in_data),
        .word_valid (wr_en),
        .word_data  (wr_data),
        .byte_cnt   (byte_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        cpu_rst  = 1'b1;
        done     = 1'b0;
        start_go = 1'b0;
        err_set  = 1'b0;
        err_code = ERR_NONE;
        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    start_go = 1'b1;
                    state_d  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (len_n == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
`endif
                    end else if (32'(len_n) > DEPTH) begin
                        state_d  = ST_ERR;
                        err_set  = 1'b1;
                        err_code = ERR_LEN;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                in_ready = 1'b1;
                if (bus.in_valid && byte_cnt == 2'd3 && last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = ST_CSUM;
`else
                    state_d = ST_FLUSH;
`endif
                end
            end
            // Holds the core in reset for the cycle of the final write so
            // DONE never overlaps an outstanding memory write.
            ST_FLUSH: state_d = ST_DONE;
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (bus.in_data == csum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_ERR;
                        err_set  = 1'b1;
                        err_code = ERR_CSUM;
                    end
                end
            end
`endif
            ST_DONE: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
                if (start) begin
                    start_go = 1'b1;
                    state_d  = ST_LEN_HI;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_hi_q     <= '0;
            len_q        <= '0;
            word_idx     <= '0;
            addr_q       <= '0;
            words_loaded <= '0;
            err          <= ERR_NONE;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else if (start_go) begin
            word_idx     <= '0;
            addr_q       <= '0;
            words_loaded <= '0;
            err          <= ERR_NONE;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            if (take && state_q == ST_LEN_HI) len_hi_q <= bus.in_data;
            if (take && state_q == ST_LEN_LO) len_q <= len_n;
            // Address is latched alongside the packed word so it equals the
            // word's index during the write and never runs past N-1.
            if (pk_valid && byte_cnt == 2'd3) begin
                word_idx <= word_idx + 1'b1;
                addr_q   <= word_idx[ADDR_W-1:0];
            end
            if (wr_en) words_loaded <= words_loaded + 11'd1;
            if (err_set) err <= err_code;
`ifdef LOADER_CHECKSUM_EN
            if (take && state_q != ST_CSUM) csum_q <= csum_q ^ bus.in_data;
`endif
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: directed load sequences with random data words
// and random byte gaps, checked against the image the bench itself builds.
// Honours LOADER_CHECKSUM_EN (appends and checks the trailing XOR byte).
module tb_prog_loader;
    import loader_pkg::*;

    localparam int unsigned AW = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cpu_rst;
    logic        done;
    logic [1:0]  err;
    logic [10:0] words_loaded;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [41:0] got[$];
    logic [31:0] exp_words[$];

    prog_loader_if #(.ADDR_W(AW)) bus ();

    prog_loader #(.DEPTH(LOADER_DEPTH), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (bus),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) got.push_back({bus.wr_addr, bus.wr_data});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        bus.in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ready", 64'(bus.in_ready), 64'd1);
        check("start_err", 64'(err), 64'(ERR_NONE));
        check("start_words", 64'(words_loaded), 64'd0);
        check("start_cpurst", 64'(cpu_rst), 64'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned w = 0;
        if ($urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(1, 2)) tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        if (bus.in_ready !== 1'b1) check("ready_timeout", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Builds the stream for exp_words, sends it and checks timing and writes.
    task automatic run_load(input bit do_start, input bit bad_csum);
        logic [7:0]  q[$];
        logic [7:0]  cs;
        int unsigned n;
        n = exp_words.size();
        q.push_back(8'(n >> 8));
        q.push_back(8'(n));
        foreach (exp_words[i]) begin
            q.push_back(exp_words[i][31:24]);
            q.push_back(exp_words[i][23:16]);
            q.push_back(exp_words[i][15:8]);
            q.push_back(exp_words[i][7:0]);
        end
        cs = 8'h00;
        foreach (q[i]) cs = cs ^ q[i];
`ifdef LOADER_CHECKSUM_EN
        q.push_back(bad_csum ? ~cs : cs);
`endif
        if (do_start) start_pulse();
        got.delete();
        foreach (q[i]) send_byte(q[i]);
`ifdef LOADER_CHECKSUM_EN
        if (bad_csum) begin
            check("csum_err", 64'(err), 64'(ERR_CSUM));
            check("csum_cpurst", 64'(cpu_rst), 64'd1);
            check("csum_done", 64'(done), 64'd0);
        end else begin
            check("csum_ok_done", 64'(done), 64'd1);
            check("csum_ok_cpurst", 64'(cpu_rst), 64'd0);
        end
`else
        if (n == 0) begin
            check("n0_done", 64'(done), 64'd1);
            check("n0_wren", 64'(bus.wr_en), 64'd0);
        end else begin
            check("last_wren", 64'(bus.wr_en), 64'd1);
            check("last_done_early", 64'(done), 64'd0);
            tick();
            check("last_done", 64'(done), 64'd1);
            check("last_cpurst", 64'(cpu_rst), 64'd0);
            check("last_wren_off", 64'(bus.wr_en), 64'd0);
        end
`endif
        repeat (2) tick();
        check("num_writes", 64'(got.size()), 64'(n));
        for (int i = 0; i < int'(n); i++) begin
            if (i < got.size()) begin
                check("wr_addr", 64'(got[i][41:32]), 64'(i));
                check("wr_data", 64'(got[i][31:0]), 64'(exp_words[i]));
            end
        end
        check("words_loaded", 64'(words_loaded), 64'(n));
    endtask

    task automatic fill(input int unsigned n);
        exp_words.delete();
        for (int unsigned i = 0; i < n; i++) exp_words.push_back($urandom());
    endtask

    initial begin
        rst          = 1'b0;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) tick();
        check("rst_ready", 64'(bus.in_ready), 64'd0);
        check("rst_wren", 64'(bus.wr_en), 64'd0);
        check("rst_waddr", 64'(bus.wr_addr), 64'd0);
        check("rst_wdata", 64'(bus.wr_data), 64'd0);
        check("rst_cpurst", 64'(cpu_rst), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_words", 64'(words_loaded), 64'd0);

        rst = 1'b1;
        repeat (6) tick();
        check("idle_cpurst", 64'(cpu_rst), 64'd1);
        check("idle_ready", 64'(bus.in_ready), 64'd0);
        check("idle_writes", 64'(got.size()), 64'd0);

        // Reference image: two instructions.
        exp_words.delete();
        exp_words.push_back(32'h20080005);
        exp_words.push_back(32'h24090007);
        run_load(1'b1, 1'b0);

        // Length 1001 exceeds capacity.
        start_pulse();
        got.delete();
        send_byte(8'h03);
        send_byte(8'hE9);
        check("len_err", 64'(err), 64'(ERR_LEN));
        check("len_cpurst", 64'(cpu_rst), 64'd1);
        check("len_done", 64'(done), 64'd0);
        check("len_ready", 64'(bus.in_ready), 64'd0);
        repeat (3) tick();
        check("len_writes", 64'(got.size()), 64'd0);
        check("len_words", 64'(words_loaded), 64'd0);
        start_pulse();
        fill(3);
        run_load(1'b0, 1'b0);

        // Empty image followed by a one-word image.
        fill(0);
        run_load(1'b1, 1'b0);
        fill(1);
        run_load(1'b1, 1'b0);

        repeat (4) begin
            fill($urandom_range(1, 8));
            run_load(1'b1, 1'b0);
        end

        // Full-capacity image.
        fill(LOADER_DEPTH);
        run_load(1'b1, 1'b0);

        // Reset after 5 of 8 data bytes.
        start_pulse();
        got.delete();
        send_byte(8'h00);
        send_byte(8'h02);
        repeat (5) send_byte(8'($urandom()));
        #2 rst = 1'b0;
        #1;
        check("mid_rst_wren", 64'(bus.wr_en), 64'd0);
        check("mid_rst_ready", 64'(bus.in_ready), 64'd0);
        check("mid_rst_cpurst", 64'(cpu_rst), 64'd1);
        check("mid_rst_words", 64'(words_loaded), 64'd0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (4) tick();
        check("mid_rst_writes", 64'(got.size()), 64'd1);
        check("mid_rst_idle_ready", 64'(bus.in_ready), 64'd0);
        check("mid_rst_idle_done", 64'(done), 64'd0);
        fill(2);
        run_load(1'b1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        fill(3);
        run_load(1'b1, 1'b0);
        run_load(1'b1, 1'b1);
        start_pulse();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader that fills the instruction memory read by the single-cycle core's fetch stage. It accepts a byte stream over a valid/ready handshake and packs it into 32-bit big-endian words. Each word is written to consecutive word addresses starting at 0. The core is held in reset until the image is fully written, then released. The loader sits between the host byte source and the instruction-memory write port, and drives the core's active-high `rst`.

## Interface
- `DEPTH`, 1000: instruction-memory capacity in words.
- `ADDR_W`, 10: word-address width (matches the core's 10-bit PC).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a load.
- `in_valid` in 1: the byte-source data is valid.
- `in_data` in 8: stream byte.
- `in_ready` out 1: the loader accepts a byte this cycle.
- `wr_en` out 1: instruction-memory write strobe, one cycle.
- `wr_addr` out `ADDR_W`: word address.
- `wr_data` out 32: instruction word.
- `cpu_rst` out 1: active-high reset to the core.
- `done` out 1: image loaded; the core is running.
- `err` out 2: 00 none, 01 length > `DEPTH`, 10 checksum mismatch.
- `words_loaded` out 11: count of words written in this load.

## Operation
- A byte is accepted in any cycle where `in_valid && in_ready`.
- Stream format: `LEN_HI`, `LEN_LO` (16-bit word count N, big-endian), then 4·N data bytes, MSB first. With `LOADER_CHECKSUM_EN` defined, one trailing checksum byte follows.
- FSM states and transitions:
  - IDLE –start→ LEN_HI.
  - LEN_HI → LEN_LO.
  - LEN_LO: N==0 → DONE (or CSUM); N>DEPTH → ERR (err=01); otherwise → DATA.
  - DATA: after the 4N-th byte → DONE, or → CSUM when the macro is defined.
  - CSUM: match → DONE; mismatch → ERR (err=10).
  - DONE and ERR: –start→ LEN_HI.
- `in_ready` is 1 in LEN_HI, LEN_LO, DATA and CSUM, and 0 elsewhere. The loader never stalls mid-image.
- Byte counter is 2 bits and wraps 3→0 each word. The word address starts at 0 and increments after each write. The address never exceeds N−1 ≤ DEPTH−1.
- `cpu_rst` is 1 in every state except DONE. `done` is 1 only in DONE. `err` holds its code in ERR and clears on `start`.
- `words_loaded` increments on each `wr_en` and clears on `start`.
- `start` is ignored in LEN_HI, LEN_LO, DATA and CSUM.
- Reset mid-load: return to IDLE immediately and abandon any partial word. No `wr_en` is issued after reset assertion.

## Timing
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `cpu_rst`=1, `done`=0, `err`=00, `words_loaded`=0, state IDLE.
- `start` sampled in cycle t puts the FSM in LEN_HI, with `in_ready`=1, at t+1.
- Fourth byte of a word accepted in cycle k → `wr_en`=1 at k+1 for exactly one cycle, with `wr_addr`/`wr_data` stable that cycle.
- Last data byte accepted at k (no checksum) → `wr_en` at k+1; `done`=1 and `cpu_rst`=0 at k+2, so the final write lands before the core fetches.
- With checksum: the checksum byte is accepted at k → DONE or ERR at k+1. It always follows the final write.
- N==0: LEN_LO accepted at k → DONE at k+1 with no writes.
- Maximum throughput is one byte per cycle.

## Configuration
- `LOADER_CHECKSUM_EN`:
  - Defined: the loader keeps a running XOR over all bytes, including `LEN_HI` and `LEN_LO`. It expects one trailing byte equal to that XOR; mismatch → ERR with err=10, and the core stays in reset.
  - Undefined: no CSUM state, and err=10 is never produced.

## Structure
- Shared package `loader_pkg` holds:
  - the state enum;
  - the err codes (`ERR_NONE`, `ERR_LEN`, `ERR_CSUM`);
  - the `DEPTH` default.
- One sub-module, `word_packer`: shifts bytes in MSB-first, holds the 2-bit byte counter, and emits a one-cycle word-valid pulse with the packed word. The FSM, address counter and checksum live in `prog_loader`.

## Test plan
- Reset released, no `start` → `cpu_rst`=1, `in_ready`=0, `wr_en`=0 indefinitely.
- `start`; bytes 00 02 20 08 00 05 24 09 00 07 → writes (0, 0x20080005) and (1, 0x24090007). `done`=1, `cpu_rst`=0 two cycles after the last byte; `words_loaded`=2.
- `start`; length 0x03E9 (1001) → err=01, `cpu_rst`=1, no writes. A following `start` clears err.
- `start`; length 0; then a second load of 1 word → DONE with no writes on the first load. The second load writes address 0; `words_loaded`=1.
- Reset asserted after 5 of 8 data bytes → no further `wr_en`, state IDLE. The next load starts writing at address 0.
- With `LOADER_CHECKSUM_EN`: valid image with correct XOR → DONE; the same image with the checksum byte flipped → err=10, `cpu_rst`=1.
